adc_ltc2308_responder: RTL and testbench

//  Synthesizable SPI responder that stands in for the DE1 LTC2308 ADC, the slave end of the
//  ADC_SCLK/ADC_CS_N/ADC_DIN/ADC_DOUT link driven by the ADC controller. It decodes the 6-bit

---
 rtl/adc_ltc2308_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_adc_ltc2308_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_ltc2308_responder.sv
// adc_ltc2308_responder
// SPI slave that imitates the DE1 LTC2308 ADC. It decodes the 6-bit config word
// clocked in on ADC_DIN, runs a timed conversion once CS_N rises, and returns the
// selected channel's 12-bit result MSB-first on ADC_DOUT during the next frame.
//
// Handshake and timing: there is no valid/ready pair on this block. The
// controller owns ADC_SCLK and ADC_CS_N. Every pin edge is seen through a
// SYNC_STAGES-deep synchroniser plus one delay flop, so the FSM acts on an edge
// SYNC_STAGES+1 CLOCK cycles after it happens on the pin. CLOCK must therefore
// run at least 8x faster than ADC_SCLK. SYNC_STAGES must be 2 or more.
// STATE_DBG exposes the FSM state (0 IDLE, 1 SHIFT, 2 CONVERT).
module adc_ltc2308_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  input  logic [95:0] CH_DATA,
  output logic        BUSY,
  output logic        CFG_VALID,
  output logic [5:0]  CFG,
  output logic        FRAME_ERR,
  output logic [1:0]  STATE_DBG
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CONVERT = 2'd2
  } state_t;

  // Synchroniser chains: bit 0 is the newest sample, bit SYNC_STAGES-1 the oldest.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  logic sclk_s;
  logic cs_s;
  logic din_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  state_t          state_q,     state_d;
  logic [11:0]     result_q,    result_d;
  logic [11:0]     sr_q,        sr_d;
  logic [5:0]      cfg_sr_q,    cfg_sr_d;
  logic [3:0]      bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0]   conv_cnt_q,  conv_cnt_d;
  logic            dout_q,      dout_d;
  logic            busy_q,      busy_d;
  logic            cfg_valid_q, cfg_valid_d;
  logic [5:0]      cfg_q,       cfg_d;
  logic            frame_err_q, frame_err_d;

  logic [2:0]      ch_sel;
  logic [6:0]      ch_base;
  logic [11:0]     ch_raw;
  logic [11:0]     capture_val;

  // Bring the three pins into the CLOCK domain and keep a delayed copy for edges.
  // CS_N resets high so that leaving reset never looks like a frame start.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   ADC_CS_N};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0],  ADC_DIN};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // Channel select and result formatting from the accepted config word.
  // Bits of CFG: [5] S/D, [4] O/S, [3] S1, [2] S0, [1] UNI, [0] SLP (ignored).
  // Differential mode is not modelled and always captures zero.
  always_comb begin
    ch_sel  = {cfg_q[3], cfg_q[2], cfg_q[4]};
    ch_base = 7'(ch_sel) * 7'd12;
    ch_raw  = CH_DATA[ch_base +: 12];
    if (!cfg_q[5]) begin
      capture_val = 12'h000;
    end else begin
      capture_val = ch_raw ^ {~cfg_q[1], 11'b0};
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      result_q    <= 12'h000;
      sr_q        <= 12'h000;
      cfg_sr_q    <= 6'h00;
      bit_cnt_q   <= 4'd0;
      conv_cnt_q  <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_q       <= 6'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      sr_q        <= sr_d;
      cfg_sr_q    <= cfg_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      conv_cnt_q  <= conv_cnt_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_q       <= cfg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic. CS_N edges always win over SCLK edges in the same cycle.
  // sr_q holds the result bits still to be sent, left-justified, zero-filled,
  // so bits past the twelfth naturally read as 0.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    sr_d        = sr_q;
    cfg_sr_d    = cfg_sr_q;
    bit_cnt_d   = bit_cnt_q;
    conv_cnt_d  = conv_cnt_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    cfg_valid_d = 1'b0;
    cfg_d       = cfg_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          sr_d      = {result_q[10:0], 1'b0};
          dout_d    = result_q[11];
          bit_cnt_d = 4'd0;
          cfg_sr_d  = 6'h00;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          // The line is released between frames, so DOUT parks low.
          dout_d = 1'b0;
          if (bit_cnt_q >= 4'd6) begin
            cfg_d       = cfg_sr_q;
            cfg_valid_d = 1'b1;
            busy_d      = 1'b1;
            conv_cnt_d  = CW'(CONV_CYCLES - 1);
            state_d     = CONVERT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          if (sclk_rise) begin
            if (bit_cnt_q < 4'd6) begin
              cfg_sr_d = {cfg_sr_q[4:0], din_s};
            end
            if (bit_cnt_q != 4'd15) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          if (sclk_fall) begin
            dout_d = sr_q[11];
            sr_d   = {sr_q[10:0], 1'b0};
          end
        end
      end

      CONVERT: begin
        if (cs_fall) begin
          // Aborted conversion: keep the old result and serve it in this frame.
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = SHIFT;
          sr_d        = {result_q[10:0], 1'b0};
          dout_d      = result_q[11];
          bit_cnt_d   = 4'd0;
          cfg_sr_d    = 6'h00;
        end else if (conv_cnt_q == '0) begin
          result_d    = capture_val;
          busy_d      = 1'b0;
          state_d     = IDLE;
          frame_err_d = ~cfg_q[5];
        end else begin
          conv_cnt_d = conv_cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ADC_DOUT  = dout_q;
  assign BUSY      = busy_q;
  assign CFG_VALID = cfg_valid_q;
  assign CFG       = cfg_q;
  assign FRAME_ERR = frame_err_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_adc_ltc2308_responder.sv
// Directed bench for adc_ltc2308_responder: frames are driven with SCLK at
// 1/16 of CLOCK, and DOUT is sampled as the controller would on SCLK rise.
module tb_adc_ltc2308_responder;

  logic        CLOCK    = 1'b0;
  logic        RESET    = 1'b0;
  logic        ADC_SCLK = 1'b0;
  logic        ADC_CS_N = 1'b1;
  logic        ADC_DIN  = 1'b0;
  logic        ADC_DOUT;
  logic [95:0] CH_DATA  = '0;
  logic        BUSY;
  logic        CFG_VALID;
  logic [5:0]  CFG;
  logic        FRAME_ERR;
  logic [1:0]  STATE_DBG;

  int n_cmp  = 0;
  int n_err  = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;

  adc_ltc2308_responder #(
    .CONV_CYCLES(80),
    .SYNC_STAGES(2)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_DIN   (ADC_DIN),
    .ADC_DOUT  (ADC_DOUT),
    .CH_DATA   (CH_DATA),
    .BUSY      (BUSY),
    .CFG_VALID (CFG_VALID),
    .CFG       (CFG),
    .FRAME_ERR (FRAME_ERR),
    .STATE_DBG (STATE_DBG)
  );

  // Clock and pulse counters
  always #10 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (CFG_VALID) cv_cnt++;
    if (FRAME_ERR) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  // One full frame: CS_N low, nclk SCLK pulses with cfg on DIN, CS_N high.
  task automatic frame(input logic [5:0] cfg, input int nclk, output logic [15:0] rd);
    rd = '0;
    ADC_CS_N = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nclk; i++) begin
      ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
      wait_clk(8);
      ADC_SCLK = 1'b1;
      rd = {rd[14:0], ADC_DOUT};
      wait_clk(8);
      ADC_SCLK = 1'b0;
    end
    wait_clk(8);
    ADC_CS_N = 1'b1;
    ADC_DIN  = 1'b0;
  endtask

  task automatic settle(input int n, output int busy_hi);
    busy_hi = 0;
    repeat (n) begin
      @(negedge CLOCK);
      if (BUSY) busy_hi++;
    end
  endtask

  // Single-ended config word for channel n: ch = {S1,S0,O/S}.
  function automatic logic [5:0] se_cfg(input int n, input logic uni);
    logic [2:0] c;
    c = 3'(n);
    return {1'b1, c[0], c[2], c[1], uni, 1'b0};
  endfunction

  initial begin
    logic [15:0] rd;
    int bh;
    int cv0;
    int fe0;

    // Reset
    CH_DATA[12 +: 12] = 12'hA5C;
    RESET = 1'b0;
    wait_clk(4);
    chk("rst_dout",      ADC_DOUT,  0);
    chk("rst_busy",      BUSY,      0);
    chk("rst_cfg_valid", CFG_VALID, 0);
    chk("rst_cfg",       CFG,       0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_state",     STATE_DBG, 0);
    RESET = 1'b1;
    wait_clk(4);

    // 1: first frame returns zero, second frame returns CH1
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    frame(6'b110010, 12, rd);
    chk("t1_frame1_dout", rd[11:0], 12'h000);
    settle(120, bh);
    chk("t1_busy_len",   bh, 80);
    chk("t1_cfg",        CFG, 6'h32);
    chk("t1_cfg_valid",  cv_cnt - cv0, 1);
    chk("t1_no_err",     fe_cnt - fe0, 0);
    frame(6'b110010, 16, rd);
    chk("t1_frame2_16b", rd, 16'hA5C0);
    settle(120, bh);

    // 2: sweep all single-ended channels, UNI=1
    for (int n = 0; n < 8; n++) CH_DATA[12*n +: 12] = 12'(n * 257);
    frame(se_cfg(0, 1'b1), 12, rd);
    chk("t2_prev", rd[11:0], 12'hA5C);
    settle(120, bh);
    for (int n = 1; n <= 8; n++) begin
      frame(se_cfg(n % 8, 1'b1), 12, rd);
      chk($sformatf("t2_ch%0d", n - 1), rd[11:0], 12'((n - 1) * 257));
      settle(120, bh);
    end

    // 3: bipolar format around mid-scale
    CH_DATA[0 +: 12] = 12'h000;
    frame(6'h20, 12, rd);
    settle(120, bh);
    CH_DATA[0 +: 12] = 12'hFFF;
    frame(6'h20, 12, rd);
    chk("t3_bip_zero", rd[11:0], 12'h800);
    settle(120, bh);
    frame(6'h20, 12, rd);
    chk("t3_bip_full", rd[11:0], 12'h7FF);
    settle(120, bh);

    // 4: short frame is rejected
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    frame(se_cfg(5, 1'b1), 4, rd);
    settle(120, bh);
    chk("t4_busy_low",   bh, 0);
    chk("t4_frame_err",  fe_cnt - fe0, 1);
    chk("t4_no_valid",   cv_cnt - cv0, 0);
    chk("t4_state_idle", STATE_DBG, 0);
    frame(se_cfg(3, 1'b1), 12, rd);
    chk("t4_prev_kept", rd[11:0], 12'h7FF);
    settle(120, bh);

    // 5: CS_N falls during conversion
    frame(se_cfg(6, 1'b1), 12, rd);
    chk("t5_ch3", rd[11:0], 12'h303);
    fe0 = fe_cnt;
    wait_clk(13);
    chk("t5_busy_before", BUSY, 1);
    frame(se_cfg(5, 1'b1), 12, rd);
    chk("t5_old_result", rd[11:0], 12'h303);
    chk("t5_busy_dropped", BUSY, 0);
    chk("t5_frame_err", fe_cnt - fe0, 1);
    settle(120, bh);
    frame(6'h02, 12, rd);
    chk("t5_ch6_never_seen", rd[11:0], 12'h505);
    fe0 = fe_cnt;
    settle(120, bh);
    chk("t5_diff_err", fe_cnt - fe0, 1);
    frame(se_cfg(5, 1'b1), 12, rd);
    chk("t5_diff_zero", rd[11:0], 12'h000);
    settle(120, bh);

    // 6: reset mid-frame with DOUT high (result is 505, bit 10 set)
    ADC_CS_N = 1'b0;
    wait_clk(8);
    ADC_SCLK = 1'b1;
    wait_clk(8);
    ADC_SCLK = 1'b0;
    wait_clk(5);
    chk("t6_dout_high",  ADC_DOUT,  1);
    chk("t6_state_shift", STATE_DBG, 1);
    RESET = 1'b0;
    #1;
    chk("t6_rst_dout",  ADC_DOUT,  0);
    chk("t6_rst_state", STATE_DBG, 0);
    ADC_CS_N = 1'b1;
    wait_clk(3);
    RESET = 1'b1;
    wait_clk(4);
    frame(se_cfg(1, 1'b1), 12, rd);
    chk("t6_after_reset", rd[11:0], 12'h000);
    settle(120, bh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
